// File: rtl/des_key_scheduler.sv
// des_key_scheduler
//   Sequenced DES key-schedule generator. A 64-bit key goes through PC-1
//   once on start. The C/D halves are then rotated round by round: left for
//   encryption, right for decryption. Each round presents one 48-bit PC-2
//   round key over a valid/ready handshake.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request a new schedule (sampled only in IDLE)
//   decrypt     mode captured with start: 0 = K1..K16, 1 = K16..K1
//   key_in      64-bit DES key including parity bits, captured with start
//   abort       synchronous cancel, highest priority
//   rk_ready    consumer accepts the current round key
//   rk_valid    rk_data / rk_round are valid
//   rk_data     48-bit round key (PC-2 of current C||D)
//   rk_round    emission index 0..15
//   busy        high while the schedule is running
//   done        one-cycle pulse after the final round key is accepted
//   parity_err  sticky key-parity error (only with DES_KEY_PARITY_CHK_EN)
//
// Build option
//   DES_KEY_PARITY_CHK_EN : when defined, start checks each key byte for odd
//   parity. A key with a bad byte is refused and parity_err is raised.
//
// state | meaning
// IDLE  | waiting for start, no valid round key
// RUN   | round key rk_round presented, advancing on each handshake
module des_key_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic        abort,
  input  logic        rk_ready,
  output logic        rk_valid,
  output logic [47:0] rk_data,
  output logic [3:0]  rk_round,
  output logic        busy,
  output logic        done
`ifdef DES_KEY_PARITY_CHK_EN
  ,
  output logic        parity_err
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nx;
  logic [27:0] c_reg, d_reg;
  logic [3:0]  rnd;
  logic        mode_reg;

  logic        key_ok;
  logic        hs;
  logic        do_load, do_adv, do_fin;
  logic        par_fail;

  logic [55:0] cd0;
  logic [27:0] c_ld, d_ld, c_adv, d_adv;
  logic [47:0] rk_ld, rk_adv;
  logic [4:0]  rnd_next_round;

  // DES numbers key bits 1..64 from the MSB, hence k[64-n].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    pc1 = {k[64-57], k[64-49], k[64-41], k[64-33], k[64-25], k[64-17], k[64-9],
           k[64-1],  k[64-58], k[64-50], k[64-42], k[64-34], k[64-26], k[64-18],
           k[64-10], k[64-2],  k[64-59], k[64-51], k[64-43], k[64-35], k[64-27],
           k[64-19], k[64-11], k[64-3],  k[64-60], k[64-52], k[64-44], k[64-36],
           k[64-63], k[64-55], k[64-47], k[64-39], k[64-31], k[64-23], k[64-15],
           k[64-7],  k[64-62], k[64-54], k[64-46], k[64-38], k[64-30], k[64-22],
           k[64-14], k[64-6],  k[64-61], k[64-53], k[64-45], k[64-37], k[64-29],
           k[64-21], k[64-13], k[64-5],  k[64-28], k[64-20], k[64-12], k[64-4]};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    pc2 = {cd[56-14], cd[56-17], cd[56-11], cd[56-24], cd[56-1],  cd[56-5],
           cd[56-3],  cd[56-28], cd[56-15], cd[56-6],  cd[56-21], cd[56-10],
           cd[56-23], cd[56-19], cd[56-12], cd[56-4],  cd[56-26], cd[56-8],
           cd[56-16], cd[56-7],  cd[56-27], cd[56-20], cd[56-13], cd[56-2],
           cd[56-41], cd[56-52], cd[56-31], cd[56-37], cd[56-47], cd[56-55],
           cd[56-30], cd[56-40], cd[56-51], cd[56-45], cd[56-33], cd[56-48],
           cd[56-44], cd[56-49], cd[56-39], cd[56-56], cd[56-34], cd[56-53],
           cd[56-46], cd[56-42], cd[56-50], cd[56-36], cd[56-29], cd[56-32]};
  endfunction

  // Rotation amount for DES round r (1..16). Decrypt starts from C0/D0,
  // which equals C16/D16, so its first round needs no rotation.
  function automatic logic [1:0] shift_amt(input logic [4:0] r, input logic dec);
    if (dec && r == 5'd1)
      shift_amt = 2'd0;
    else if (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16)
      shift_amt = 2'd1;
    else
      shift_amt = 2'd2;
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] x, input logic dec,
                                      input logic [4:0] r);
    logic [1:0] amt;
    amt = shift_amt(r, dec);
    rot = x;
    if (!dec) begin
      if (amt == 2'd1)      rot = {x[26:0], x[27]};
      else if (amt == 2'd2) rot = {x[25:0], x[27:26]};
    end else begin
      if (amt == 2'd1)      rot = {x[0], x[27:1]};
      else if (amt == 2'd2) rot = {x[1:0], x[27:2]};
    end
  endfunction

`ifdef DES_KEY_PARITY_CHK_EN
  assign key_ok = (^key_in[63:56]) & (^key_in[55:48]) & (^key_in[47:40]) &
                  (^key_in[39:32]) & (^key_in[31:24]) & (^key_in[23:16]) &
                  (^key_in[15:8])  & (^key_in[7:0]);
`else
  // Parity bits are dropped by PC-1; the sink keeps them visibly consumed.
  logic unused_parity_bits;
  assign unused_parity_bits = &{1'b0, key_in[56], key_in[48], key_in[40], key_in[32],
                                key_in[24], key_in[16], key_in[8], key_in[0]};
  assign key_ok = 1'b1;
`endif

  // Datapath: load value and next-round value are computed in parallel.
  assign cd0            = pc1(key_in);
  assign c_ld           = rot(cd0[55:28], decrypt, 5'd1);
  assign d_ld           = rot(cd0[27:0],  decrypt, 5'd1);
  assign rk_ld          = pc2({c_ld, d_ld});
  assign rnd_next_round = {1'b0, rnd} + 5'd2;
  assign c_adv          = rot(c_reg, mode_reg, rnd_next_round);
  assign d_adv          = rot(d_reg, mode_reg, rnd_next_round);
  assign rk_adv         = pc2({c_adv, d_adv});

  assign hs = rk_valid & rk_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!abort && start && key_ok) state_nx = RUN;
      RUN: begin
        if (abort)                      state_nx = IDLE;
        else if (hs && rnd == 4'd15)    state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    do_load  = 1'b0;
    do_adv   = 1'b0;
    do_fin   = 1'b0;
    par_fail = 1'b0;
    if (!abort) begin
      case (state)
        IDLE: begin
          do_load  = start & key_ok;
          par_fail = start & ~key_ok;
        end
        RUN: begin
          do_adv = hs & (rnd != 4'd15);
          do_fin = hs & (rnd == 4'd15);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg    <= '0;
      d_reg    <= '0;
      rnd      <= '0;
      mode_reg <= 1'b0;
      rk_data  <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      rnd      <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else if (do_load) begin
      c_reg    <= c_ld;
      d_reg    <= d_ld;
      rk_data  <= rk_ld;
      rnd      <= '0;
      mode_reg <= decrypt;
      rk_valid <= 1'b1;
      done     <= 1'b0;
    end else if (do_adv) begin
      c_reg    <= c_adv;
      d_reg    <= d_adv;
      rk_data  <= rk_adv;
      rnd      <= rnd + 4'd1;
      done     <= 1'b0;
    end else if (do_fin) begin
      rk_valid <= 1'b0;
      done     <= 1'b1;
    end else begin
      done     <= 1'b0;
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                parity_err <= 1'b0;
    else if (abort || do_load) parity_err <= 1'b0;
    else if (par_fail)         parity_err <= 1'b1;
  end
`else
  logic unused_par_fail;
  assign unused_par_fail = par_fail;
`endif

  assign rk_round = rnd;
  assign busy     = (state == RUN);

endmodule

// File: tb/tb_des_key_scheduler.sv
module tb_des_key_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic        abort;
  logic        rk_ready;
  logic        rk_valid;
  logic [47:0] rk_data;
  logic [3:0]  rk_round;
  logic        busy;
  logic        done;
`ifdef DES_KEY_PARITY_CHK_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  // Round keys K1..K16 for KEY (classic worked example)
  logic [47:0] exp_k [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  des_key_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .decrypt    (decrypt),
    .key_in     (key_in),
    .abort      (abort),
    .rk_ready   (rk_ready),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rk_round   (rk_round),
    .busy       (busy),
    .done       (done)
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key_in = '0;
    abort = 1'b0; rk_ready = 1'b0;
    #3;
    n_checks++;
    if ({rk_valid, rk_data, rk_round, busy, done} !== 55'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {rk_valid, rk_data, rk_round, busy, done});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({rk_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid/busy/done got %b expected 000", {rk_valid, busy, done});
    end
  endtask

  task automatic test_encrypt();
    key_in = KEY; decrypt = 1'b0; rk_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_data !== exp_k[i] || rk_round !== 4'(i)) begin
        n_fail++;
        $display("FAIL enc_key[%0d]: got v=%b b=%b data=%h round=%0d expected v=1 b=1 data=%h round=%0d",
                 i, rk_valid, busy, rk_data, rk_round, exp_k[i], i);
      end
      step();
    end
    n_checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_done: got done=%b v=%b b=%b expected 1 0 0", done, rk_valid, busy);
    end
  endtask

  // Entered in the cycle where done is high: the decrypt start must be taken.
  task automatic test_back_to_back();
    key_in = KEY; decrypt = 1'b1; rk_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rk_data !== exp_k[15-i] || rk_round !== 4'(i) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL dec_key[%0d]: got v=%b data=%h round=%0d done=%b expected v=1 data=%h round=%0d done=0",
                 i, rk_valid, rk_data, rk_round, done, exp_k[15-i], i);
      end
      step();
    end
    n_checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_done: got done=%b v=%b expected 1 0", done, rk_valid);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] lfsr;
    int          idx;
    int          stalls;
    bit          finished;
    logic        rdy;
    bit          hs;
    lfsr = 16'hACE1; idx = 0; stalls = 0; finished = 0;
    key_in = KEY; decrypt = 1'b0; rk_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      rdy  = lfsr[0];
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      hs   = rk_valid && rdy;
      rk_ready = rdy;
      step();
      if (hs) begin
        idx++;
        if (idx == 16) begin
          finished = 1;
          n_checks++;
          if (done !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b v=%b expected 1 0", done, rk_valid);
          end
        end else begin
          n_checks++;
          if (rk_data !== exp_k[idx] || rk_round !== 4'(idx) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_key[%0d]: got data=%h round=%0d done=%b expected data=%h round=%0d done=0",
                     idx, rk_data, rk_round, done, exp_k[idx], idx);
          end
        end
      end else begin
        stalls++;
        n_checks++;
        if (rk_valid !== 1'b1 || rk_data !== exp_k[idx] || rk_round !== 4'(idx) || done !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_stall[%0d]: got v=%b data=%h round=%0d done=%b expected v=1 data=%h round=%0d done=0",
                   idx, rk_valid, rk_data, rk_round, done, exp_k[idx], idx);
        end
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_timeout: got %0d handshakes expected 16", idx);
    end
    rk_ready = 1'b1;
    step();
  endtask

  task automatic test_abort_start_busy();
    key_in = KEY; decrypt = 1'b0; rk_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    n_checks++;
    if (rk_round !== 4'd5 || rk_data !== exp_k[5]) begin
      n_fail++;
      $display("FAIL ab_round5: got round=%0d data=%h expected 5 %h", rk_round, rk_data, exp_k[5]);
    end
    key_in = 64'h0; decrypt = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (rk_round !== 4'd6 || rk_data !== exp_k[6] || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored: got round=%0d data=%h busy=%b expected 6 %h 1",
               rk_round, rk_data, busy, exp_k[6]);
    end
    step();
    n_checks++;
    if (rk_round !== 4'd7) begin
      n_fail++;
      $display("FAIL ab_round7: got %0d expected 7", rk_round);
    end
    abort = 1'b1; start = 1'b1; key_in = KEY; decrypt = 1'b0;
    step();
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_round !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_state: got v=%b b=%b done=%b round=%0d expected 0 0 0 0",
               rk_valid, busy, done, rk_round);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got done=%b v=%b expected 0 0", done, rk_valid);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_data !== exp_k[0]) begin
      n_fail++;
      $display("FAIL restart: got v=%b round=%0d data=%h expected 1 0 %h",
               rk_valid, rk_round, rk_data, exp_k[0]);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit saw;
    saw = 0;
    key_in = KEY; decrypt = 1'b0; rk_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    n_checks++;
    if (rk_round !== 4'd9 || rk_data !== exp_k[9]) begin
      n_fail++;
      $display("FAIL rst_round9: got round=%0d data=%h expected 9 %h", rk_round, rk_data, exp_k[9]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rk_valid, rk_data, rk_round, busy, done} !== 55'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h expected 0", {rk_valid, rk_data, rk_round, busy, done});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done !== 1'b0 || rk_valid !== 1'b0) saw = 1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL rst_no_done: got done/valid activity after reset expected none");
    end
  endtask

`ifdef DES_KEY_PARITY_CHK_EN
  task automatic test_parity();
    key_in = 64'h133457799BBCDFF0; decrypt = 1'b0; rk_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (parity_err !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_bad: got err=%b v=%b b=%b expected 1 0 0", parity_err, rk_valid, busy);
    end
    key_in = KEY; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (parity_err !== 1'b0 || rk_valid !== 1'b1 || rk_data !== exp_k[0]) begin
      n_fail++;
      $display("FAIL parity_good: got err=%b v=%b data=%h expected 0 1 %h",
               parity_err, rk_valid, rk_data, exp_k[0]);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back();
    test_backpressure();
    test_abort_start_busy();
    test_reset_mid_run();
`ifdef DES_KEY_PARITY_CHK_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
